// File: rtl/imem_pkg.sv
// Shared constants, loader state encoding and address helper for the instruction memory loader.
package imem_pkg;

  localparam int unsigned IMEM_DEPTH      = 1024;
  localparam int unsigned IMEM_ADDR_SHIFT = 2;

  typedef logic [2:0] loader_state_t;

  localparam loader_state_t StIdle  = 3'd0;
  localparam loader_state_t StClear = 3'd1;
  localparam loader_state_t StLoad  = 3'd2;
  localparam loader_state_t StFlush = 3'd3;
  localparam loader_state_t StDone  = 3'd4;

  // Word index to byte address.
  function automatic logic [31:0] imem_word_addr(input logic [31:0] idx);
    return idx << IMEM_ADDR_SHIFT;
  endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Big-endian byte-to-word assembler: tracks the byte lane and builds the word being loaded.
module imem_word_packer
  import imem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_i,
  input  logic        byte_en_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_complete_o,
  output logic        partial_o
);

  logic [1:0]  idx_q, idx_d;
  logic [31:0] word_q, word_d;
  logic [31:0] lane_word;

  always_comb begin
    lane_word = word_q;
    if (byte_en_i) begin
      unique case (idx_q)
        2'd0: lane_word[31:24] = byte_i;
        2'd1: lane_word[23:16] = byte_i;
        2'd2: lane_word[15:8]  = byte_i;
        2'd3: lane_word[7:0]   = byte_i;
      endcase
    end
  end

  assign word_o          = lane_word;
  assign word_complete_o = byte_en_i && (idx_q == 2'd3);
  // Bytes remain unwritten after this cycle's transfer is counted.
  assign partial_o       = byte_en_i ? (idx_q != 2'd3) : (idx_q != 2'd0);

  always_comb begin
    idx_d  = idx_q;
    word_d = lane_word;
    if (byte_en_i) begin
      idx_d = idx_q + 2'd1;
    end
    if (clear_i || word_complete_o) begin
      word_d = '0;
    end
    if (clear_i) begin
      idx_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q  <= '0;
      word_q <= '0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction memory loader: clears the word array, then writes a big-endian byte stream into it.
module imem_loader
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH = IMEM_DEPTH,
  parameter int unsigned CNT_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             byte_valid_i,
  input  logic [7:0]       byte_data_i,
  output logic             byte_ready_o,
  input  logic             eos_i,
  output logic             wr_en_o,
  output logic [31:0]      wr_addr_o,
  output logic [31:0]      wr_data_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             full_o,
  output logic [CNT_W-1:0] word_count_o
);

  loader_state_t    state_q, state_d;
  logic             byte_ready_q, byte_ready_d;
  logic             wr_en_q, wr_en_d;
  logic [31:0]      wr_addr_q, wr_addr_d;
  logic [31:0]      wr_data_q, wr_data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             full_q, full_d;
  logic             eos_pend_q, eos_pend_d;
  logic [CNT_W-1:0] word_count_q, word_count_d;
  logic [CNT_W-1:0] clr_idx_q, clr_idx_d;

  logic        transfer, eos_any, last_word, write_word;
  logic        pk_clear, pk_complete, pk_partial;
  logic [31:0] pk_word;

  assign transfer = byte_valid_i & byte_ready_q;
  assign eos_any  = eos_i | eos_pend_q;

  imem_word_packer u_packer (
    .clk             (clk),
    .rst             (rst),
    .clear_i         (pk_clear),
    .byte_en_i       (transfer),
    .byte_i          (byte_data_i),
    .word_o          (pk_word),
    .word_complete_o (pk_complete),
    .partial_o       (pk_partial)
  );

  always_comb begin
    state_d      = state_q;
    byte_ready_d = byte_ready_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    busy_d       = busy_q;
    done_d       = done_q;
    full_d       = full_q;
    eos_pend_d   = eos_pend_q;
    word_count_d = word_count_q;
    clr_idx_d    = clr_idx_q;
    pk_clear     = 1'b0;
    last_word    = 1'b0;
    write_word   = 1'b0;

    case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          state_d      = StClear;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          full_d       = 1'b0;
          eos_pend_d   = 1'b0;
          word_count_d = '0;
          clr_idx_d    = '0;
          wr_en_d      = 1'b1;
          wr_addr_d    = '0;
          wr_data_d    = '0;
          pk_clear     = 1'b1;
        end
      end
      StClear: begin
        // An eos seen while clearing is held and ends the load as soon as LOAD is entered.
        eos_pend_d = eos_any;
        if (32'(clr_idx_q) == DEPTH - 1) begin
          state_d      = StLoad;
          byte_ready_d = ~eos_any;
        end else begin
          wr_en_d   = 1'b1;
          clr_idx_d = clr_idx_q + CNT_W'(1);
          wr_addr_d = imem_word_addr(32'(clr_idx_q) + 32'd1);
        end
      end
      StLoad: begin
        last_word  = pk_complete && (32'(word_count_q) + 32'd1 == DEPTH);
        write_word = pk_complete || (eos_any && pk_partial);
        if (write_word) begin
          wr_en_d      = 1'b1;
          wr_addr_d    = imem_word_addr(32'(word_count_q));
          wr_data_d    = pk_word;
          word_count_d = word_count_q + CNT_W'(1);
        end
        if (eos_any || last_word) begin
          byte_ready_d = 1'b0;
          eos_pend_d   = 1'b0;
          pk_clear     = 1'b1;
          // FLUSH is the cycle in which the final word write is presented.
          if (write_word) begin
            state_d = StFlush;
          end else begin
            state_d = StDone;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      StFlush: begin
        state_d = StDone;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        full_d  = (32'(word_count_q) == DEPTH);
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      byte_ready_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      full_q       <= 1'b0;
      eos_pend_q   <= 1'b0;
      word_count_q <= '0;
      clr_idx_q    <= '0;
    end else begin
      state_q      <= state_d;
      byte_ready_q <= byte_ready_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      full_q       <= full_d;
      eos_pend_q   <= eos_pend_d;
      word_count_q <= word_count_d;
      clr_idx_q    <= clr_idx_d;
    end
  end

  assign byte_ready_o = byte_ready_q;
  assign wr_en_o      = wr_en_q;
  assign wr_addr_o    = wr_addr_q;
  assign wr_data_o    = wr_data_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign full_o       = full_q;
  assign word_count_o = word_count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader with a queue-based model of the expected write sequence.
module tb_imem_loader;
  import imem_pkg::*;

  localparam int unsigned DEPTH = IMEM_DEPTH;
  localparam int unsigned CNT_W = 11;

  logic             clk = 1'b0;
  logic             rst;
  logic             start_i, byte_valid_i, eos_i;
  logic [7:0]       byte_data_i;
  logic             byte_ready_o, wr_en_o, busy_o, done_o, full_o;
  logic [31:0]      wr_addr_o, wr_data_o;
  logic [CNT_W-1:0] word_count_o;

  imem_loader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .byte_valid_i (byte_valid_i),
    .byte_data_i  (byte_data_i),
    .byte_ready_o (byte_ready_o),
    .eos_i        (eos_i),
    .wr_en_o      (wr_en_o),
    .wr_addr_o    (wr_addr_o),
    .wr_data_o    (wr_data_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .full_o       (full_o),
    .word_count_o (word_count_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t        exp_q[$];
  wr_t        got_q[$];
  logic [7:0] stim[$];
  int         acc_idx = 0;
  int         vectors = 0;
  int         miscompares = 0;
  bit         mon_en = 1'b0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Compare process: every write and every accepted byte is checked against the model.
  always @(negedge clk) begin
    wr_t e, g;
    if (!rst && mon_en) begin
      if (wr_en_o) begin
        g.addr = wr_addr_o;
        g.data = wr_data_o;
        got_q.push_back(g);
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_write: got addr %h data %h, required no write",
                   wr_addr_o, wr_data_o);
        end else begin
          e = exp_q.pop_front();
          check32("write_addr", wr_addr_o, e.addr);
          check32("write_data", wr_data_o, e.data);
        end
      end
      if (byte_valid_i && byte_ready_o) begin
        if (acc_idx < stim.size()) begin
          check32("accepted_byte", {24'h0, byte_data_i}, {24'h0, stim[acc_idx]});
        end else begin
          vectors++;
          miscompares++;
          $display("FAIL extra_byte_accepted: got byte %h at index %0d, required none",
                   byte_data_i, acc_idx);
        end
        acc_idx++;
      end
      check32("wr_or_ready_while_not_busy", {31'h0, (wr_en_o | byte_ready_o) & ~busy_o}, 32'h0);
      check32("busy_and_done", {31'h0, busy_o & done_o}, 32'h0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  // Model: DEPTH zero words, then the stream packed big-endian, zero-padded, capped at DEPTH.
  task automatic build_expect(output int unsigned nw);
    int unsigned n;
    logic [31:0] word;
    wr_t e;
    n = stim.size();
    if (n > DEPTH * 4) n = DEPTH * 4;
    exp_q.delete();
    got_q.delete();
    acc_idx = 0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      e.addr = i * 4;
      e.data = 32'h0;
      exp_q.push_back(e);
    end
    nw = (n + 3) / 4;
    for (int unsigned w = 0; w < nw; w++) begin
      word = 32'h0;
      for (int k = 0; k < 4; k++) begin
        if (w * 4 + k < n) word = word | (32'(stim[w * 4 + k]) << (24 - 8 * k));
      end
      e.addr = w * 4;
      e.data = word;
      exp_q.push_back(e);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit with_eos, input int limit,
                           output bit ok);
    int t = 0;
    byte_valid_i = 1'b1;
    byte_data_i  = b;
    while (!byte_ready_o && t < limit) begin
      tick();
      t++;
    end
    ok = byte_ready_o;
    if (ok) begin
      eos_i = with_eos;
      tick();
      eos_i = 1'b0;
    end
    byte_valid_i = 1'b0;
    byte_data_i  = 8'($urandom);
  endtask

  task automatic run_load(input string tag, input bit eos_on_last, input bit gaps,
                          input bit noise, input bit eos_in_clear, output int unsigned nw);
    bit ok;
    int t;
    int n_acc;
    build_expect(nw);
    n_acc = (stim.size() > DEPTH * 4) ? DEPTH * 4 : stim.size();
    pulse_start();
    check32({tag, "_busy_after_start"}, {31'h0, busy_o}, 32'h1);
    check32({tag, "_done_after_start"}, {31'h0, done_o}, 32'h0);
    if (noise) begin
      repeat ($urandom_range(1, 50)) tick();
      pulse_start();
    end
    if (eos_in_clear) begin
      repeat (20) tick();
      eos_i = 1'b1;
      tick();
      eos_i = 1'b0;
    end
    for (int i = 0; i < stim.size(); i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      if (noise && $urandom_range(0, 15) == 0) pulse_start();
      send_byte(stim[i], eos_on_last && (i == stim.size() - 1),
                (i < DEPTH * 4) ? 3000 : 20, ok);
      check32($sformatf("%s_accept%0d", tag, i), {31'h0, ok}, {31'h0, i < DEPTH * 4});
    end
    if (!eos_on_last && !eos_in_clear && stim.size() < DEPTH * 4) begin
      t = 0;
      while (!byte_ready_o && t < 3000) begin
        tick();
        t++;
      end
      check32({tag, "_ready_before_eos"}, {31'h0, byte_ready_o}, 32'h1);
      if (gaps) repeat ($urandom_range(0, 3)) tick();
      eos_i = 1'b1;
      tick();
      eos_i = 1'b0;
    end
    t = 0;
    while (!done_o && t < 3000) begin
      tick();
      t++;
    end
    check32({tag, "_done"}, {31'h0, done_o}, 32'h1);
    repeat (2) tick();
    check32({tag, "_busy_end"}, {31'h0, busy_o}, 32'h0);
    check32({tag, "_ready_end"}, {31'h0, byte_ready_o}, 32'h0);
    check32({tag, "_word_count"}, 32'(word_count_o), nw);
    check32({tag, "_full"}, {31'h0, full_o}, {31'h0, nw == DEPTH});
    check32({tag, "_pending_writes"}, exp_q.size(), 32'h0);
    check32({tag, "_bytes_accepted"}, acc_idx, n_acc);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned nw;
    int t;
    rst          = 1'b1;
    start_i      = 1'b0;
    byte_valid_i = 1'b0;
    byte_data_i  = 8'h0;
    eos_i        = 1'b0;
    repeat (3) tick();
    check32("rst_wr_en", {31'h0, wr_en_o}, 32'h0);
    check32("rst_busy", {31'h0, busy_o}, 32'h0);
    check32("rst_done", {31'h0, done_o}, 32'h0);
    check32("rst_full", {31'h0, full_o}, 32'h0);
    check32("rst_ready", {31'h0, byte_ready_o}, 32'h0);
    check32("rst_count", 32'(word_count_o), 32'h0);
    check32("rst_addr", wr_addr_o, 32'h0);
    check32("rst_data", wr_data_o, 32'h0);
    rst    = 1'b0;
    mon_en = 1'b1;
    repeat (3) tick();
    check32("idle_ready", {31'h0, byte_ready_o}, 32'h0);

    // Two whole words, separate eos.
    stim = '{8'h00, 8'h00, 8'h00, 8'h13, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_load("two_words", 1'b0, 1'b0, 1'b0, 1'b0, nw);
    check32("two_words_nwrites", got_q.size(), DEPTH + 2);
    if (got_q.size() == DEPTH + 2) begin
      check32("two_words_w0_addr", got_q[DEPTH].addr, 32'h0);
      check32("two_words_w0_data", got_q[DEPTH].data, 32'h00000013);
      check32("two_words_w1_addr", got_q[DEPTH + 1].addr, 32'h4);
      check32("two_words_w1_data", got_q[DEPTH + 1].data, 32'hDEADBEEF);
    end
    check32("two_words_count_lit", 32'(word_count_o), 32'd2);

    // Partial final word, eos on the last transfer.
    stim = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    run_load("flush", 1'b1, 1'b0, 1'b0, 1'b0, nw);
    check32("flush_nwrites", got_q.size(), DEPTH + 2);
    if (got_q.size() == DEPTH + 2) begin
      check32("flush_w0_data", got_q[DEPTH].data, 32'h11223344);
      check32("flush_w1_addr", got_q[DEPTH + 1].addr, 32'h4);
      check32("flush_w1_data", got_q[DEPTH + 1].data, 32'h55000000);
    end

    // Empty stream: eos in LOAD, then eos held over from CLEAR.
    stim.delete();
    run_load("empty", 1'b0, 1'b0, 1'b0, 1'b0, nw);
    check32("empty_count_lit", 32'(word_count_o), 32'h0);
    run_load("eos_in_clear", 1'b0, 1'b0, 1'b0, 1'b1, nw);
    check32("eos_in_clear_nwrites", got_q.size(), DEPTH);

    // Reset in the middle of the clear sweep.
    stim.delete();
    build_expect(nw);
    pulse_start();
    t = 0;
    while (!(wr_en_o && wr_addr_o == 32'h40) && t < 200) begin
      tick();
      t++;
    end
    check32("midclear_reached_0x40", wr_addr_o, 32'h40);
    #2;
    rst = 1'b1;
    #1;
    check32("midclear_rst_wr_en", {31'h0, wr_en_o}, 32'h0);
    check32("midclear_rst_addr", wr_addr_o, 32'h0);
    check32("midclear_rst_busy", {31'h0, busy_o}, 32'h0);
    check32("midclear_rst_count", 32'(word_count_o), 32'h0);
    exp_q.delete();
    repeat (2) tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check32("midclear_idle_wr_en", {31'h0, wr_en_o}, 32'h0);
    end
    check32("midclear_idle_busy", {31'h0, busy_o}, 32'h0);

    // Random streams with valid gaps and ignored start pulses.
    for (int r = 0; r < 6; r++) begin
      stim.delete();
      repeat ($urandom_range(1, 40)) stim.push_back(8'($urandom));
      run_load($sformatf("rand%0d", r), 1'($urandom_range(0, 1)), 1'b1, 1'b1, 1'b0, nw);
    end

    // Overfill: three bytes beyond capacity must never be accepted.
    stim.delete();
    repeat (DEPTH * 4 + 3) stim.push_back(8'($urandom));
    run_load("full", 1'b0, 1'b0, 1'b0, 1'b0, nw);
    check32("full_nwrites", got_q.size(), 2 * DEPTH);
    if (got_q.size() == 2 * DEPTH) begin
      check32("full_last_addr", got_q[2 * DEPTH - 1].addr, 32'hFFC);
    end
    check32("full_count_lit", 32'(word_count_o), 32'd1024);
    check32("full_flag_lit", {31'h0, full_o}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
